mul_seq32: RTL and testbench



---
 rtl/mul_seq32_pkg.sv | 27 ++
 rtl/mul_seq32_if.sv | 26 ++
 rtl/adder32.sv | 43 ++++
 rtl/mul_seq32.sv | 152 +++++++++++++++
 tb/tb_mul_seq32.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/mul_seq32_pkg.sv
// Shared definitions for the sequential multiplier: state encodings and iteration count.
// The hazard unit imports this package to decode the multiplier's busy state.
// Nothing here holds state; it only provides types, constants and one decode helper.
package mul_seq32_pkg;

    localparam int XLEN  = 32;
    localparam int ITERS = 32;
    localparam int CNT_W = 5;

    // Count value of the final shift-add iteration.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERS - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PREP   = 3'd1,
        ST_CALC   = 3'd2,
        ST_NEG_LO = 3'd3,
        ST_NEG_HI = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    // The unit is busy, and stalls the pipeline, in every state except IDLE.
    function automatic logic state_busy(input state_t s);
        return (s != ST_IDLE);
    endfunction

endpackage

// File: rtl/mul_seq32_if.sv
// Request/result bundle between the EX stage and the sequential multiplier.
// Pure wiring: no latency of its own.
// start is only honoured while busy is low; results are held until the next done.
interface mul_seq32_if;
    import mul_seq32_pkg::*;

    logic            start;
    logic            sgn;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] prod_hi;
    logic [XLEN-1:0] prod_lo;

    modport master (
        output start, sgn, a, b,
        input  busy, done, prod_hi, prod_lo
    );

    modport slave (
        input  start, sgn, a, b,
        output busy, done, prod_hi, prod_lo
    );

endinterface

// File: rtl/adder32.sv
// 32-bit adder built as eight 4-bit carry-lookahead groups with ripple between groups.
// Purely combinational, zero cycles.
// No handshake; the caller muxes operands.
module adder32
    import mul_seq32_pkg::*;
(
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    input  logic            i_cin,
    output logic [XLEN-1:0] o_sum,
    output logic            o_cout
);

    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [4:0] w_c;
    logic       w_carry;

    // Lookahead inside each nibble, carry ripples from nibble to nibble.
    always_comb begin
        w_g     = '0;
        w_p     = '0;
        w_c     = '0;
        o_sum   = '0;
        w_carry = i_cin;
        for (int n = 0; n < XLEN / 4; n++) begin
            w_g    = i_a[n*4 +: 4] & i_b[n*4 +: 4];
            w_p    = i_a[n*4 +: 4] ^ i_b[n*4 +: 4];
            w_c[0] = w_carry;
            w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
            w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
            w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                   | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
            w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                   | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                   | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);
            o_sum[n*4 +: 4] = w_p ^ w_c[3:0];
            w_carry = w_c[4];
        end
        o_cout = w_carry;
    end

endmodule

// File: rtl/mul_seq32.sv
// Sequential 32x32->64 multiplier (signed/unsigned), one shift-add per clock on a shared adder32.
// Latency: done 34 cycles after start capture, 36 when the product needs negation.
// start is ignored while busy (including the done cycle); busy stalls the pipeline.
module mul_seq32
    import mul_seq32_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    mul_seq32_if.slave bus
);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [XLEN-1:0] r_mcand;
    logic [XLEN-1:0] r_mplr;
    logic [XLEN-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic            r_sgn;
    logic            r_neg;
    logic            r_ncy;
    logic [XLEN-1:0] r_prod_hi;
    logic [XLEN-1:0] r_prod_lo;

    logic [XLEN-1:0] w_add_a;
    logic [XLEN-1:0] w_add_b;
    logic            w_add_cin;
    logic [XLEN-1:0] w_sum;
    logic            w_cout;
    logic            w_neg_a;
    logic            w_neg_b;
    logic [XLEN-1:0] w_shift_acc;
    logic [XLEN-1:0] w_shift_mplr;

    assign w_neg_a = bus.sgn & bus.a[XLEN-1];
    assign w_neg_b = r_sgn & r_mplr[XLEN-1];

    // One shift-add step: {carry, sum, mplr} shifted right by one.
    assign w_shift_acc  = {w_cout, w_sum[XLEN-1:1]};
    assign w_shift_mplr = {w_sum[0], r_mplr[XLEN-1:1]};

    adder32 u_adder (
        .i_a    (w_add_a),
        .i_b    (w_add_b),
        .i_cin  (w_add_cin),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    // State register; reset aborts any operation in flight.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state decode and the per-state adder operand mux (idle states add 0+0+0).
    always_comb begin
        w_state_nxt = r_state;
        w_add_a     = '0;
        w_add_b     = '0;
        w_add_cin   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_add_a     = w_neg_a ? ~bus.a : bus.a;
                    w_add_cin   = w_neg_a;
                    w_state_nxt = ST_PREP;
                end
            end
            ST_PREP: begin
                w_add_a     = w_neg_b ? ~r_mplr : r_mplr;
                w_add_cin   = w_neg_b;
                w_state_nxt = ST_CALC;
            end
            ST_CALC: begin
                w_add_a = r_acc;
                w_add_b = r_mplr[0] ? r_mcand : '0;
                if (r_cnt == CNT_LAST) w_state_nxt = r_neg ? ST_NEG_LO : ST_DONE;
            end
            ST_NEG_LO: begin
                w_add_a     = ~r_mplr;
                w_add_cin   = 1'b1;
                w_state_nxt = ST_NEG_HI;
            end
            ST_NEG_HI: begin
                w_add_a     = ~r_acc;
                w_add_cin   = r_ncy;
                w_state_nxt = ST_DONE;
            end
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Working registers: operand capture, magnitude fix-up, shift-add, two-word negate.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mcand <= '0;
            r_mplr  <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_sgn   <= 1'b0;
            r_neg   <= 1'b0;
            r_ncy   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_mcand <= w_sum;
                        r_mplr  <= bus.b;
                        r_sgn   <= bus.sgn;
                        r_neg   <= bus.sgn & (bus.a[XLEN-1] ^ bus.b[XLEN-1]);
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_ncy   <= 1'b0;
                    end
                end
                ST_PREP:   r_mplr <= w_sum;
                ST_CALC: begin
                    r_acc  <= w_shift_acc;
                    r_mplr <= w_shift_mplr;
                    r_cnt  <= r_cnt + 5'd1;
                end
                ST_NEG_LO: begin
                    r_mplr <= w_sum;
                    r_ncy  <= w_cout;
                end
                ST_NEG_HI: r_acc <= w_sum;
                default: ;
            endcase
        end
    end

    // Result registers load only on entry to DONE, so partial products never leak out.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_prod_hi <= '0;
            r_prod_lo <= '0;
        end else if (r_state == ST_CALC && w_state_nxt == ST_DONE) begin
            r_prod_hi <= w_shift_acc;
            r_prod_lo <= w_shift_mplr;
        end else if (r_state == ST_NEG_HI) begin
            r_prod_hi <= w_sum;
            r_prod_lo <= r_mplr;
        end
    end

    assign bus.busy    = state_busy(r_state);
    assign bus.done    = (r_state == ST_DONE);
    assign bus.prod_hi = r_prod_hi;
    assign bus.prod_lo = r_prod_lo;

endmodule

// File: tb/tb_mul_seq32.sv
// Bench for mul_seq32: directed corners, busy/start rules, mid-op reset and random operands.
// Expected products come from plain 64-bit arithmetic; latency from the negation rule.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_mul_seq32;
    import mul_seq32_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    mul_seq32_if bus ();

    mul_seq32 u_dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: extend each operand to 64 bits (sign or zero) and multiply.
    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                             input logic s);
        logic [63:0] xa, xb;
        xa = s ? {{32{a[31]}}, a} : {32'd0, a};
        xb = s ? {{32{b[31]}}, b} : {32'd0, b};
        return xa * xb;
    endfunction

    // poke > 0: pulse start (a=5, b=6) at that cycle of the op; poke < 0: pulse it during done.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input int poke, input string tag);
        logic [63:0] exp_p;
        int          exp_lat;
        int          k;
        exp_p   = ref_prod(a, b, s);
        exp_lat = (s && (a[31] ^ b[31])) ? 36 : 34;
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.sgn   = s;
        @(negedge clk);
        k = 1;
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
        bus.sgn   = 1'($urandom);
        check({tag, " busy_rise"}, 64'(bus.busy), 64'd1);
        while (bus.done !== 1'b1 && k < 200) begin
            if (k == poke) begin
                bus.start = 1'b1;
                bus.a     = 32'd5;
                bus.b     = 32'd6;
                bus.sgn   = 1'b0;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        bus.start = 1'b0;
        check({tag, " latency"}, 64'(k), 64'(exp_lat));
        check({tag, " product"}, {bus.prod_hi, bus.prod_lo}, exp_p);
        if (poke < 0) begin
            bus.start = 1'b1;
            bus.a     = 32'd5;
            bus.b     = 32'd6;
            bus.sgn   = 1'b0;
        end
        @(negedge clk);
        bus.start = 1'b0;
        check({tag, " done_width"}, 64'(bus.done), 64'd0);
        check({tag, " busy_fall"}, 64'(bus.busy), 64'd0);
        check({tag, " prod_hold"}, {bus.prod_hi, bus.prod_lo}, exp_p);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h8000_0000;
            1:       return 32'h0000_0000;
            2:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int done_seen;
        logic [31:0] ra, rb;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.sgn   = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(negedge clk);
        check("reset busy",    64'(bus.busy), 64'd0);
        check("reset done",    64'(bus.done), 64'd0);
        check("reset prod_hi", 64'(bus.prod_hi), 64'd0);
        check("reset prod_lo", 64'(bus.prod_lo), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, "u_max");
        run_op(32'hFFFF_FFFD, 32'h0000_0007, 1'b1, 0, "s_neg");
        run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 0, "s_min_sq");
        run_op(32'h0000_0000, 32'h8000_0000, 1'b1, 0, "s_zero_neg");
        run_op(32'h0001_F00D, 32'h0000_0BAD, 1'b0, 10, "start_while_busy");
        run_op(32'hFFFF_1234, 32'h0000_5678, 1'b1, -1, "start_in_done");
        run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0, "back_to_back");

        for (int i = 0; i < 16; i++) begin
            ra = pick_operand();
            rb = pick_operand();
            run_op(ra, rb, 1'($urandom), 0, $sformatf("rand%0d", i));
        end

        // Abort an operation with an off-edge reset in its 15th cycle.
        bus.start = 1'b1;
        bus.a     = 32'h1234_5678;
        bus.b     = 32'h9ABC_DEF0;
        bus.sgn   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (14) @(negedge clk);
        check("pre_reset busy", 64'(bus.busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("mid_reset busy",    64'(bus.busy), 64'd0);
        check("mid_reset done",    64'(bus.done), 64'd0);
        check("mid_reset prod_hi", 64'(bus.prod_hi), 64'd0);
        check("mid_reset prod_lo", 64'(bus.prod_lo), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) done_seen++;
        end
        check("aborted_op_silent", 64'(done_seen), 64'd0);
        run_op(32'd3, 32'd4, 1'b0, 0, "after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
